// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one stalling mem_system between the instruction-fetch port and the
//   data-memory port. A granted request is latched into the mem_* registers,
//   a one-cycle Rd/Wr strobe is issued, the arbiter waits for Done and then
//   returns a one-cycle done pulse plus registered read data to the owner.
//   Round-robin arbitration; after reset the data port wins the first tie.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch read request (level) and address
//   if_rdata/if_done         fetch read data (held) and completion pulse
//   if_stall                 fetch stall = if_req & ~if_done
//   dm_rd/dm_wr/dm_addr      data read/write request (level) and address
//   dm_wdata                 store data
//   dm_rdata/dm_done         load data (held) and completion pulse
//   dm_stall                 data stall = (dm_rd | dm_wr) & ~dm_done
//   mem_addr/mem_wdata       registered address / write data to mem_system
//   mem_rd/mem_wr            one-cycle strobes to mem_system
//   mem_rdata/mem_done       mem_system DataOut / Done
//   mem_stall/mem_err        mem_system Stall / err
//   err                      sticky error flag, cleared only by rst
//   busy                     high whenever the sequencer is not idle
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        dm_rd,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_stall,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    input  logic        mem_stall,
    input  logic        mem_err,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;      // 0 = fetch, 1 = data
    logic        last_q, last_d;        // port granted most recently
    logic        is_wr_q, is_wr_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] dm_rdata_q, dm_rdata_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_done_q, if_done_d;
    logic        dm_done_q, dm_done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic        dm_req;
    logic        grant_dm;

    assign dm_req   = dm_rd | dm_wr;
    // Data wins when it is alone, or on a tie when fetch was served last.
    assign grant_dm = dm_req & (~if_req | ~last_q);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        is_wr_d     = is_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        err_d       = err_q | mem_err;

        unique case (state_q)
            IDLE: begin
                if (!mem_stall && (if_req || dm_req)) begin
                    state_d = ISSUE;
                    owner_d = grant_dm;
                    if (grant_dm) begin
                        // rd & wr together is flagged and executed as a write
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        is_wr_d     = dm_wr;
                        mem_wr_d    = dm_wr;
                        mem_rd_d    = ~dm_wr;
                        if (dm_rd && dm_wr) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        mem_addr_d = if_addr;
                        is_wr_d    = 1'b0;
                        mem_rd_d   = 1'b1;
                    end
                end
            end
            ISSUE, WAIT: begin
                if (mem_done) begin
                    state_d   = RESP;
                    if_done_d = ~owner_q;
                    dm_done_d = owner_q;
                    if (!is_wr_q) begin
                        if (owner_q) begin
                            dm_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b0;
            is_wr_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            is_wr_q     <= is_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign if_stall  = if_req & ~if_done_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_done   = dm_done_q;
    assign dm_stall  = dm_req & ~dm_done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule
